// File: rtl/cmos_frame_gen.sv
// cmos_frame_gen
//
// Camera-side test frame source. Emits a CMOS-sensor-style stream (vsync
// pulse, one href per line, gapped pixel valid, RGB565 data) at a runtime
// width/height. It stands in for the sensor byte-merge stage ahead of the
// rotation pre-processor.
//
// Ports:
//   cam_pclk         - pixel clock
//   rst_n            - asynchronous active-low reset
//   gen_en           - run frames; only looked at on a frame boundary
//   pattern_sel[1:0] - 0 row/col, 1 colour bars, 2 frame counter, 3 checker
//   t_width[9:0]     - pixels per line, latched at frame start
//   t_high[9:0]      - lines per frame, latched at frame start
//   cmos_frame_vsync - high during the vsync phase
//   cmos_frame_href  - high while a line is active
//   cmos_frame_valid - pixel strobe, only while href is high
//   cmos_frame_data  - RGB565 pixel, held between strobes, 0 outside lines
//   frame_done       - one-cycle pulse after the last VFP cycle
//   frame_cnt[7:0]   - completed frame count, wraps
//
// All outputs are registered copies of values decoded from the current
// state, so every output lags the FSM by exactly one cycle. Durations are
// unaffected; only the absolute position shifts.
module cmos_frame_gen #(
  parameter int VS_LEN     = 16,
  parameter int VBP_LEN    = 32,
  parameter int HBLANK_LEN = 64,
  parameter int VFP_LEN    = 32,
  parameter int PIX_DIV    = 2
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  input  logic [9:0]  t_width,
  input  logic [9:0]  t_high,
  output logic        cmos_frame_vsync,
  output logic        cmos_frame_href,
  output logic        cmos_frame_valid,
  output logic [15:0] cmos_frame_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_LINE,
    ST_HBLANK,
    ST_VFP
  } state_t;

  localparam logic [15:0] VS_END  = 16'(VS_LEN - 1);
  localparam logic [15:0] VBP_END = 16'(VBP_LEN - 1);
  localparam logic [15:0] HB_END  = 16'(HBLANK_LEN - 1);
  localparam logic [15:0] VFP_END = 16'(VFP_LEN - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [9:0]  width_s, high_s;
  logic [1:0]  pat_s;
  logic [9:0]  row, col, bar_pos;
  logic [2:0]  bar_idx;

  logic        start_ok, last_row, frame_start, pix_valid;
  logic [15:0] line_end;
  logic [9:0]  bar_width;
  logic [15:0] pix_data;
  logic        vsync_d, href_d, valid_d, done_d;
  logic [15:0] data_d;

  // A zero-sized frame would never terminate, so it blocks the start.
  assign start_ok    = gen_en && (t_width != 10'd0) && (t_high != 10'd0);
  assign line_end    = (PIX_DIV == 2) ? ({5'd0, width_s, 1'b0} - 16'd1)
                                      : ({6'd0, width_s} - 16'd1);
  assign last_row    = (row == (high_s - 10'd1));
  assign frame_start = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
  // With PIX_DIV=2 the strobe lands on even line cycles, so the first
  // pixel coincides with the first href cycle.
  assign pix_valid   = (state == ST_LINE) && ((PIX_DIV == 1) || !cnt[0]);
  assign bar_width   = (width_s[9:3] == 7'd0) ? 10'd1 : {3'd0, width_s[9:3]};

  // State register
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_VSYNC;
      ST_VSYNC:  if (cnt == VS_END) state_nxt = ST_VBP;
      ST_VBP:    if (cnt == VBP_END) state_nxt = ST_LINE;
      ST_LINE:   if (cnt == line_end) state_nxt = last_row ? ST_VFP : ST_HBLANK;
      ST_HBLANK: if (cnt == HB_END) state_nxt = ST_LINE;
      ST_VFP:    if (cnt == VFP_END) state_nxt = start_ok ? ST_VSYNC : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Phase counter, frame configuration shadows, row/column/bar tracking.
  // Bars are tracked incrementally to avoid a divider on the pixel path.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 16'd0;
      width_s <= 10'd0;
      high_s  <= 10'd0;
      pat_s   <= 2'd0;
      row     <= 10'd0;
      col     <= 10'd0;
      bar_pos <= 10'd0;
      bar_idx <= 3'd0;
    end else begin
      if ((state_nxt != state) || (state == ST_IDLE)) cnt <= 16'd0;
      else                                           cnt <= cnt + 16'd1;

      if (frame_start) begin
        width_s <= t_width;
        high_s  <= t_high;
        pat_s   <= pattern_sel;
        row     <= 10'd0;
      end else if ((state == ST_LINE) && (state_nxt != ST_LINE)) begin
        row <= row + 10'd1;
      end

      if (state != ST_LINE) begin
        col     <= 10'd0;
        bar_pos <= 10'd0;
        bar_idx <= 3'd0;
      end else if (pix_valid) begin
        col <= col + 10'd1;
        if (bar_pos == (bar_width - 10'd1)) begin
          bar_pos <= 10'd0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + 10'd1;
        end
      end
    end
  end

  // Pixel value for the current column under the latched pattern
  always_comb begin
    pix_data = 16'h0000;
    case (pat_s)
      2'd0: pix_data = {row[5:0], col};
      2'd1: begin
        case (bar_idx)
          3'd0:    pix_data = 16'hF800;
          3'd1:    pix_data = 16'h07E0;
          3'd2:    pix_data = 16'h001F;
          3'd3:    pix_data = 16'hFFE0;
          3'd4:    pix_data = 16'hF81F;
          3'd5:    pix_data = 16'h07FF;
          3'd6:    pix_data = 16'hFFFF;
          default: pix_data = 16'h0000;
        endcase
      end
      2'd2:    pix_data = {frame_cnt, frame_cnt};
      default: pix_data = (row[3] ^ col[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  // Output decode; data holds its last pixel between strobes inside a line
  always_comb begin
    vsync_d = (state == ST_VSYNC);
    href_d  = (state == ST_LINE);
    valid_d = pix_valid;
    done_d  = (state == ST_VFP) && (cnt == VFP_END);
    data_d  = 16'h0000;
    if (state == ST_LINE) data_d = pix_valid ? pix_data : cmos_frame_data;
  end

  // Output registers
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= 16'h0000;
      frame_done       <= 1'b0;
      frame_cnt        <= 8'd0;
    end else begin
      cmos_frame_vsync <= vsync_d;
      cmos_frame_href  <= href_d;
      cmos_frame_valid <= valid_d;
      cmos_frame_data  <= data_d;
      frame_done       <= done_d;
      if (done_d) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: doc/cmos_frame_gen.md
# cmos_frame_gen

Camera-side frame source for the rotation path. Produces the CMOS-style frame stream (vsync pulse, href per line, gapped pixel valid, 16-bit RGB565 data) at a runtime-selected `t_width` × `t_high`, with selectable test patterns. It sits upstream of the rotation pre-processor, standing in for the sensor byte-merge stage on bring-up boards and in verification benches.

## Interface
Parameters:
- `VS_LEN`, 16: vsync high length, cycles (≥1).
- `VBP_LEN`, 32: cycles from vsync fall to first href rise (≥1).
- `HBLANK_LEN`, 64: href-low cycles between lines (≥2).
- `VFP_LEN`, 32: cycles from last href fall to next vsync rise (≥1).
- `PIX_DIV`, 2: href cycles per pixel, 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `cam_pclk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `gen_en` in 1: run frames; sampled only at frame boundary.
- `pattern_sel` in 2: test pattern; latched at frame start.
- `t_width` in 10: pixels per line; latched at frame start.
- `t_high` in 10: lines per frame; latched at frame start.
- `cmos_frame_vsync` out 1: frame sync, high during VSYNC state.
- `cmos_frame_href` out 1: line active.
- `cmos_frame_valid` out 1: pixel strobe, only while href high.
- `cmos_frame_data` out 16: RGB565 pixel.
- `frame_done` out 1: one-cycle pulse at end of last line's VFP.
- `frame_cnt` out 8: completed frames, wraps 255→0.

## Operation
- FSM: IDLE → VSYNC → VBP → LINE ⇄ HBLANK → VFP → (VSYNC if `gen_en` else IDLE).
- IDLE: leave when `gen_en`=1 and `t_width`≠0 and `t_high`≠0; on exit, latch `t_width`, `t_high`, `pattern_sel` into shadow registers; row=0.
- VSYNC for `VS_LEN` cycles, VBP for `VBP_LEN`, LINE for `t_width*PIX_DIV` cycles, HBLANK for `HBLANK_LEN` between lines; after line `t_high-1`, go to VFP (no HBLANK) for `VFP_LEN`.
- Column counter col (10 b) counts valid pixels 0..t_width-1 per line; row (10 b) 0..t_high-1.
- Valid: PIX_DIV=1 → high every LINE cycle; PIX_DIV=2 → high on 1st, 3rd, … LINE cycles. Exactly `t_width` valids per line, first on first href cycle.
- Data (updated only with valid, held otherwise; 0 outside LINE):
  - 0: {row[5:0], col[9:0]}.
  - 1: 8 vertical bars; bar width = t_width>>3 (min 1), bar index saturates at 7; colours in order F800, 07E0, 001F, FFE0, F81F, 07FF, FFFF, 0000.
  - 2: {frame_cnt, frame_cnt} for every pixel.
  - 3: checkerboard, (row[3]^col[3]) ? FFFF : 0000.
- `gen_en` low mid-frame: current frame completes (including VFP, `frame_done`), then IDLE. Config changes mid-frame ignored until next latch.
- `frame_cnt` increments with `frame_done`.

## Timing
- All outputs registered; reset values: vsync 0, href 0, valid 0, data 0, frame_done 0, frame_cnt 0; FSM IDLE, counters 0.
- Reset assertion mid-frame: all outputs go to reset values immediately (async); restart from IDLE after release.
- First vsync rise: 2nd rising edge after `gen_en` sampled 1 in IDLE (one cycle IDLE decision, then registered output).
- Href falls exactly `t_width*PIX_DIV` cycles after rising; valid never high while href low; vsync and href never high together.
- Frame period = VS_LEN + VBP_LEN + t_high·t_width·PIX_DIV + (t_high−1)·HBLANK_LEN + VFP_LEN cycles.
- Back-to-back frames: vsync re-rises the cycle after VFP ends, with no IDLE gap.

## Test plan
- Defaults, t_width=8, t_high=4, pattern 0, gen_en held 1 → per frame 4 href pulses of 16 cycles, 8 valids each, data row 2 col 5 = 0x0805; frame period 16+32+64+192+32=336 cycles; frame_done once per frame.
- PIX_DIV=1, t_width=16, pattern 1 → bar width 2; pixels 0..15 = F800,F800,07E0,07E0,…,0000,0000.
- Pattern 2 over three frames → all pixels 0x0000, 0x0101, 0x0202; frame_cnt 1,2,3 after each frame_done.
- t_width changed 8→12 mid-frame → current frame keeps 8 valids/line; next frame 12.
- gen_en dropped during line 1 → frame completes with 4 lines, frame_done pulses, then IDLE (vsync stays 0); t_high=0 with gen_en=1 → stays IDLE.
- rst_n asserted during href → href/valid/data/vsync 0 same cycle; after release with gen_en=1, clean frame from vsync, frame_cnt=0.
